// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Brief    : Sums a run of signed multiplier products into a saturating
//            accumulator with valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 80,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic                 out_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic               w_beat;
    logic               w_last;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W:0]     w_prod_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_beat    = (r_state == S_ACCUM) && in_valid;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == r_len);

    // One guard bit above the accumulator: overflow shows as the top two bits disagreeing
    assign w_prod_ext = {{(ACC_W + 1 - 2*WIDTH){in_product[2*WIDTH-1]}}, in_product};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_sat      = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_sat) begin
            w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_len <= len;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_cnt <= w_cnt_inc;
            r_acc <= w_acc_nxt;
            if (w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Brief    : Self-checking bench for product_accumulator (80-bit and 64-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int WIDTH = 32;
    localparam int ACC_W = 80;
    localparam int CNT_W = 8;
    localparam int PW    = 2 * WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, in_valid, out_ready;
    logic [CNT_W-1:0] len;
    logic [PW-1:0]    in_product;
    logic             in_ready, out_valid, out_ovf, busy;
    logic [ACC_W-1:0] out_acc;

    logic             b_start, b_in_valid, b_out_ready;
    logic [CNT_W-1:0] b_len;
    logic [PW-1:0]    b_in_product;
    logic             b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [63:0]      b_out_acc;

    // When set, the 64-bit instance sees exactly the same stimulus as the main one
    bit               mirror = 1'b0;
    logic             m_start, m_in_valid, m_out_ready;
    logic [CNT_W-1:0] m_len;
    logic [PW-1:0]    m_in_product;
    assign m_start      = mirror ? start      : b_start;
    assign m_len        = mirror ? len        : b_len;
    assign m_in_valid   = mirror ? in_valid   : b_in_valid;
    assign m_in_product = mirror ? in_product : b_in_product;
    assign m_out_ready  = mirror ? out_ready  : b_out_ready;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always @(posedge clk) if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;

    product_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .busy(busy)
    );

    product_accumulator #(.WIDTH(WIDTH), .ACC_W(64), .CNT_W(CNT_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(m_start), .len(m_len),
        .in_valid(m_in_valid), .in_ready(b_in_ready), .in_product(m_in_product),
        .out_valid(b_out_valid), .out_ready(m_out_ready), .out_acc(b_out_acc),
        .out_ovf(b_out_ovf), .busy(b_busy)
    );

    // Reference: exact integer sum clipped to the signed w-bit range after every term
    function automatic logic signed [127:0] sat_add(input logic signed [127:0] a,
                                                    input logic [PW-1:0] p,
                                                    input int w, output bit o);
        logic signed [127:0] mx, mn, s, pe;
        mx = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn = -(128'sd1 <<< (w - 1));
        pe = {{(128-PW){p[PW-1]}}, p};
        s  = a + pe;
        o  = 1'b0;
        if (s > mx) begin s = mx; o = 1'b1; end
        else if (s < mn) begin s = mn; o = 1'b1; end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    // Holds in_valid high until the beat transfers; leaves in_valid asserted
    task automatic send_beat(input logic [PW-1:0] p, output bit ok);
        bit acc_now;
        ok = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        for (int i = 0; i < 20; i++) begin
            acc_now = in_ready;
            tick();
            if (acc_now) begin ok = 1'b1; break; end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_acc, out_valid, out_ovf, in_ready, busy} !== '0) begin
            errors++;
            $display("FAIL reset80: acc=%0h valid=%b ovf=%b ready=%b busy=%b required all 0",
                     out_acc, out_valid, out_ovf, in_ready, busy);
        end
        checks++;
        if ({b_out_acc, b_out_valid, b_out_ovf, b_in_ready, b_busy} !== '0) begin
            errors++;
            $display("FAIL reset64: acc=%0h valid=%b ovf=%b ready=%b busy=%b required all 0",
                     b_out_acc, b_out_valid, b_out_ovf, b_in_ready, b_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        bit all_ok = 1'b1;
        logic [PW-1:0] prods [3];
        prods[0] = 64'd15;
        prods[1] = -64'sd4;
        prods[2] = 64'd4;
        do_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            send_beat(prods[i], ok);
            all_ok &= ok;
        end
        in_valid = 1'b0;
        checks++;
        if (!all_ok || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: beats_ok=%b out_valid=%b in_ready=%b required 1 1 0",
                     all_ok, out_valid, in_ready);
        end
        checks++;
        if (out_acc !== 80'd15 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: acc=%0d ovf=%b required 15 0", $signed(out_acc), out_ovf);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 80'd15) begin
            errors++;
            $display("FAIL basic_idle_hold: valid=%b busy=%b acc=%0d required 0 0 15",
                     out_valid, busy, $signed(out_acc));
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit all_ok = 1'b1;
        int hs0;
        logic [PW-1:0] p;
        logic signed [127:0] e;
        p   = 64'h3FFF_FFFF_0000_0001;
        e   = 128'sd4 * $signed({64'd0, p});
        hs0 = hs_cnt;
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            send_beat(p, ok);
            all_ok &= ok;
            in_valid = 1'b0;
            if (i < 3) begin
                tick();
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_busy: beat=%0d valid=%b busy=%b required 0 1",
                             i, out_valid, busy);
                end
            end
        end
        checks++;
        if (!all_ok || out_valid !== 1'b1 || out_acc !== e[ACC_W-1:0] || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL stall_sum: valid=%b acc=%0h ovf=%b required 1 %0h 0",
                     out_valid, out_acc, out_ovf, e[ACC_W-1:0]);
        end
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (hs_cnt - hs0 != 4 || out_acc !== e[ACC_W-1:0]) begin
            errors++;
            $display("FAIL stall_beats: accepted=%0d acc=%0h required 4 %0h",
                     hs_cnt - hs0, out_acc, e[ACC_W-1:0]);
        end
        consume();
    endtask

    task automatic test_saturation();
        b_start = 1'b1; b_len = 8'd2; tick(); b_start = 1'b0;
        b_in_valid = 1'b1; b_in_product = 64'h4000_0000_0000_0000;
        tick(); tick();
        b_in_valid = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_acc !== 64'h7FFF_FFFF_FFFF_FFFF || b_out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: valid=%b acc=%0h ovf=%b required 1 7fffffffffffffff 1",
                     b_out_valid, b_out_acc, b_out_ovf);
        end
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;

        b_start = 1'b1; b_len = 8'd2; tick(); b_start = 1'b0;
        b_in_valid = 1'b1; b_in_product = 64'h8000_0000_0000_0000;
        tick();
        checks++;
        if (b_out_ovf !== 1'b0 || b_out_acc !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL sat_ovf_clear: acc=%0h ovf=%b required 8000000000000000 0",
                     b_out_acc, b_out_ovf);
        end
        b_in_product = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        b_in_valid = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_acc !== 64'h8000_0000_0000_0000 || b_out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: valid=%b acc=%0h ovf=%b required 1 8000000000000000 1",
                     b_out_valid, b_out_acc, b_out_ovf);
        end
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;

        b_start = 1'b1; b_len = 8'd3; tick(); b_start = 1'b0;
        b_in_valid = 1'b1; b_in_product = 64'h4000_0000_0000_0000;
        tick(); tick();
        b_in_product = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        b_in_valid = 1'b0;
        checks++;
        if (b_out_acc !== 64'h7FFF_FFFF_FFFF_FFFE || b_out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: acc=%0h ovf=%b required 7ffffffffffffffe 1",
                     b_out_acc, b_out_ovf);
        end
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        int hs0 = hs_cnt;
        do_start(8'd0);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: valid=%b acc=%0h ovf=%b ready=%b required 1 0 0 0",
                     out_valid, out_acc, out_ovf, in_ready);
        end
        start = 1'b1; len = 8'd5; in_valid = 1'b1; in_product = 64'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_acc !== '0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL len0_hold: cycle=%0d valid=%b acc=%0h ready=%b required 1 0 0",
                         i, out_valid, out_acc, in_ready);
            end
        end
        start = 1'b0; in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || hs_cnt != hs0) begin
            errors++;
            $display("FAIL len0_release: valid=%b busy=%b beats=%0d required 0 0 0",
                     out_valid, busy, hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic signed [ACC_W-1:0] e;
        do_start(8'd5);
        send_beat(64'd1000, ok);
        send_beat(64'd2000, ok);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({out_acc, out_valid, out_ovf, in_ready, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: acc=%0h valid=%b ovf=%b ready=%b busy=%b required all 0",
                     out_acc, out_valid, out_ovf, in_ready, busy);
        end
        do_start(8'd1);
        send_beat(-64'sd7, ok);
        in_valid = 1'b0;
        e = -7;
        checks++;
        if (!ok || out_valid !== 1'b1 || out_acc !== e) begin
            errors++;
            $display("FAIL reset_restart: ok=%b valid=%b acc=%0d required 1 1 -7",
                     ok, out_valid, $signed(out_acc));
        end
        consume();
    endtask

    task automatic test_random();
        bit ok, o;
        bit o80, o64;
        logic signed [127:0] e80, e64;
        logic [PW-1:0] p;
        logic signed [31:0] a, b;
        int n;
        bit done;
        mirror = 1'b1;
        for (int s = 0; s < 50; s++) begin
            n = $urandom_range(1, 20);
            e80 = 0; e64 = 0; o80 = 1'b0; o64 = 1'b0;
            do_start(n[CNT_W-1:0]);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0: p = {$urandom, $urandom};
                    1: p = PW'($signed($urandom_range(0, 200)) - 100);
                    2: begin a = $urandom; b = $urandom; p = a * b; end
                    default: p = $urandom_range(0, 1) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
                endcase
                in_valid = 1'b0;
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                send_beat(p, ok);
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_beat_timeout: seq=%0d beat=%0d", s, k);
                end
                e80 = sat_add(e80, p, ACC_W, o); o80 |= o;
                e64 = sat_add(e64, p, 64, o);    o64 |= o;
            end
            in_valid = 1'b0;
            done = 1'b0;
            for (int w = 0; w < 50; w++) begin
                if (out_valid === 1'b1 && b_out_valid === 1'b1) begin done = 1'b1; break; end
                tick();
            end
            checks++;
            if (!done || out_acc !== e80[ACC_W-1:0] || out_ovf !== o80) begin
                errors++;
                $display("FAIL rand80: seq=%0d done=%b acc=%0h ovf=%b required %0h %b",
                         s, done, out_acc, out_ovf, e80[ACC_W-1:0], o80);
            end
            checks++;
            if (!done || b_out_acc !== e64[63:0] || b_out_ovf !== o64) begin
                errors++;
                $display("FAIL rand64: seq=%0d done=%b acc=%0h ovf=%b required %0h %b",
                         s, done, b_out_acc, b_out_ovf, e64[63:0], o64);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            consume();
        end
        mirror = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
        b_start = 1'b0; b_len = '0; b_in_valid = 1'b0; b_in_product = '0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
